fpm_issue_scheduler: RTL and testbench

- Shares the single combinational 32-bit floating-point multiplier between NUM_RS multiply reservation-station entries.
- Each cycle it picks one ready entry by round-robin and registers that entry's operands onto the multiplier inputs.
- It carries the product and tag through a fixed-latency pipeline, then queues results in a small output buffer.
- Results leave the buffer onto the common data bus (CDB) through a req/grant handshake.

---
 rtl/fpm_sched_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/fpm_issue_scheduler.sv | 167 ++++++++++++++++
 tb/tb_fpm_issue_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpm_sched_pkg.sv
// Shared types and defaults for the FP multiply issue scheduler.
// Holds the datapath width, result record and default pipeline sizing.
package fpm_sched_pkg;

    localparam int FP_W           = 32;
    localparam int DEF_TAG_W      = 4;
    localparam int DEF_LAT        = 3;
    localparam int DEF_OBUF_DEPTH = 4;

    typedef struct packed {
        logic [DEF_TAG_W-1:0] tag;
        logic [FP_W-1:0]      data;
    } fpm_res_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request searching from ptr upward, wrapping.
// Ports: req (N), ptr (start index), grant (one-hot), idx (granted index), any.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx      = PW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpm_issue_scheduler.sv
// Shares one combinational FP multiplier among NUM_RS reservation stations.
// Ports: clk/rst/flush; rs_* requests and grant; fpm_a/fpm_b/fpm_out
// multiplier link; cdb_* req/grant result port; busy.
module fpm_issue_scheduler
    import fpm_sched_pkg::*;
#(
    parameter int NUM_RS     = 4,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int LAT        = DEF_LAT,
    parameter int OBUF_DEPTH = DEF_OBUF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_RS-1:0]       rs_ready,
    input  logic [NUM_RS*FP_W-1:0]  rs_op_a,
    input  logic [NUM_RS*FP_W-1:0]  rs_op_b,
    input  logic [NUM_RS*TAG_W-1:0] rs_tag,
    output logic [NUM_RS-1:0]       rs_grant,
    output logic [FP_W-1:0]         fpm_a,
    output logic [FP_W-1:0]         fpm_b,
    input  logic [FP_W-1:0]         fpm_out,
    output logic                    cdb_req,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [FP_W-1:0]         cdb_data,
    input  logic                    cdb_grant,
    output logic                    busy
);

    localparam int PW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int AW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CW = $clog2(OBUF_DEPTH) + 1;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     gidx;
    logic              issue;
    logic              can_issue;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     cnt;
    logic [CW:0]       credit_used;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [LAT-1:0]    sv;
    logic [TAG_W-1:0]  stag [LAT];
    logic [FP_W-1:0]   wdata;
    logic [FP_W-1:0]   sel_a;
    logic [FP_W-1:0]   sel_b;
    logic [TAG_W-1:0]  sel_tag;
    logic              push;
    logic              pop;
    fpm_res_t          mem [OBUF_DEPTH];
    fpm_res_t          head;

    // Credit counts slots already promised to in-flight ops, so the
    // pipeline never needs to stall and the buffer cannot overflow.
    assign credit_used = {1'b0, inflight} + {1'b0, cnt};
    assign can_issue   = !rst && !flush &&
                         (credit_used < (CW+1)'(OBUF_DEPTH));

    rr_arbiter #(.N(NUM_RS), .PW(PW)) u_arb (
        .req   (rs_ready & {NUM_RS{can_issue}}),
        .ptr   (rr_ptr),
        .grant (rs_grant),
        .idx   (gidx),
        .any   (issue)
    );

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_tag = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (rs_grant[i]) begin
                sel_a   = rs_op_a[i*FP_W +: FP_W];
                sel_b   = rs_op_b[i*FP_W +: FP_W];
                sel_tag = rs_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    assign push = sv[LAT-1];
    assign pop  = cdb_req && cdb_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            fpm_a  <= '0;
            fpm_b  <= '0;
        end else if (issue) begin
            rr_ptr <= (gidx == PW'(NUM_RS-1)) ? '0 : gidx + 1'b1;
            fpm_a  <= sel_a;
            fpm_b  <= sel_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            sv <= '0;
        end else begin
            sv[0] <= issue;
            for (int k = 1; k < LAT; k++) sv[k] <= sv[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (issue) stag[0] <= sel_tag;
        for (int k = 1; k < LAT; k++) stag[k] <= stag[k-1];
    end

    // Stage 1 captures the product; later stages only delay it.
    generate
        if (LAT > 1) begin : g_dpipe
            logic [FP_W-1:0] sd [1:LAT-1];
            always_ff @(posedge clk) begin
                sd[1] <= fpm_out;
                for (int k = 2; k < LAT; k++) sd[k] <= sd[k-1];
            end
            assign wdata = sd[LAT-1];
        end else begin : g_dcomb
            assign wdata = fpm_out;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            inflight <= '0;
        end else begin
            unique case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{tag: DEF_TAG_W'(stag[LAT-1]),
                                 data: wdata};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head     = mem[rd_ptr];
    assign cdb_req  = (cnt != '0);
    assign cdb_tag  = TAG_W'(head.tag);
    assign cdb_data = head.data;
    assign busy     = (|sv) || (cnt != '0);

endmodule

// File: tb/tb_fpm_issue_scheduler.sv
// Self-checking bench for fpm_issue_scheduler with a queue-based model.
// Directed scenarios plus per-cycle comparison against the model.
module tb_fpm_issue_scheduler;

    localparam int N   = 4;
    localparam int TW  = 4;
    localparam int LAT = 3;
    localparam int DEP = 4;

    localparam logic [31:0] OPA [4] =
        '{32'h40000000, 32'h3fc00000, 32'h40400000, 32'h3f800000};
    localparam logic [31:0] OPB [4] =
        '{32'h41100000, 32'h40400000, 32'h40a00000, 32'hc0000000};
    localparam logic [3:0] TAGS [4] = '{4'd5, 4'd6, 4'd7, 4'd8};

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [N-1:0]  rs_ready;
    logic [N*32-1:0] rs_op_a;
    logic [N*32-1:0] rs_op_b;
    logic [N*TW-1:0] rs_tag;
    logic [N-1:0]  rs_grant;
    logic [31:0]   fpm_a;
    logic [31:0]   fpm_b;
    logic [31:0]   fpm_out;
    logic          cdb_req;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_data;
    logic          cdb_grant;
    logic          busy;

    int checks = 0;
    int failures = 0;

    fpm_issue_scheduler #(
        .NUM_RS(N), .TAG_W(TW), .LAT(LAT), .OBUF_DEPTH(DEP)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rs_ready(rs_ready), .rs_op_a(rs_op_a), .rs_op_b(rs_op_b),
        .rs_tag(rs_tag), .rs_grant(rs_grant),
        .fpm_a(fpm_a), .fpm_b(fpm_b), .fpm_out(fpm_out),
        .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_grant(cdb_grant), .busy(busy)
    );

    always #5 clk = ~clk;

    // Truncating single-precision multiply for normal operands.
    function automatic logic [31:0] fmul(input logic [31:0] a,
                                         input logic [31:0] b);
        logic [47:0] m;
        int e;
        logic [22:0] f;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
        m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            f = m[46:24];
            e = e + 1;
        end else begin
            f = m[45:23];
        end
        return {a[31] ^ b[31], e[7:0], f};
    endfunction

    always_comb fpm_out = fmul(fpm_a, fpm_b);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
        int          age;
    } item_t;

    item_t       pipe_q[$];
    item_t       obuf_q[$];
    int          m_rr = 0;
    logic [31:0] m_a = 0;
    logic [31:0] m_b = 0;
    bit          started = 0;

    // Model: issue-ordered queues; an op spends LAT edges in flight,
    // then sits in the buffer until popped by a CDB grant.
    initial begin
        int gi;
        bit can;
        logic [N-1:0] eg;
        bit s_rst, s_flush, s_cg;
        item_t it;
        forever begin
            @(negedge clk);
            s_rst   = rst;
            s_flush = flush;
            s_cg    = cdb_grant;
            can = !rst && !flush && (pipe_q.size() + obuf_q.size() < DEP);
            gi = -1;
            eg = '0;
            if (can)
                for (int k = 0; k < N; k++)
                    if (gi < 0 && rs_ready[(m_rr + k) % N])
                        gi = (m_rr + k) % N;
            if (gi >= 0) eg[gi] = 1'b1;
            if (started) begin
                check("grant", 32'(rs_grant), 32'(eg));
                check("cdb_req", 32'(cdb_req), 32'(obuf_q.size() > 0));
                if (obuf_q.size() > 0) begin
                    check("cdb_tag", 32'(cdb_tag), 32'(obuf_q[0].tag));
                    check("cdb_data", cdb_data, obuf_q[0].data);
                end
                check("busy", 32'(busy),
                      32'(pipe_q.size() > 0 || obuf_q.size() > 0));
                check("fpm_a", fpm_a, m_a);
                check("fpm_b", fpm_b, m_b);
            end
            @(posedge clk);
            if (s_rst) begin
                pipe_q.delete();
                obuf_q.delete();
                m_rr = 0;
                m_a = 0;
                m_b = 0;
                started = 1;
            end else if (s_flush) begin
                pipe_q.delete();
                obuf_q.delete();
            end else begin
                if (obuf_q.size() > 0 && s_cg) obuf_q.delete(0);
                foreach (pipe_q[k]) pipe_q[k].age++;
                while (pipe_q.size() > 0 && pipe_q[0].age >= LAT) begin
                    obuf_q.push_back(pipe_q[0]);
                    pipe_q.delete(0);
                end
                if (gi >= 0) begin
                    it.tag  = TAGS[gi];
                    it.data = fmul(OPA[gi], OPB[gi]);
                    it.age  = 0;
                    pipe_q.push_back(it);
                    m_rr = (gi + 1) % N;
                    m_a  = OPA[gi];
                    m_b  = OPB[gi];
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        flush = 1'b0;
        rs_ready = '0;
        cyc();
        rst = 1'b0;
    endtask

    localparam logic [3:0] PAT [8] =
        '{4'hF, 4'h5, 4'hA, 4'h0, 4'h9, 4'h6, 4'hF, 4'h3};

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        rs_ready = '0;
        cdb_grant = 1'b0;
        for (int i = 0; i < N; i++) begin
            rs_op_a[i*32 +: 32] = OPA[i];
            rs_op_b[i*32 +: 32] = OPB[i];
            rs_tag[i*TW +: TW]  = TAGS[i];
        end
        cyc();
        @(negedge clk);
        check("rst_req", 32'(cdb_req), 32'd0);
        check("rst_tag", 32'(cdb_tag), 32'd0);
        check("rst_data", cdb_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fpm_a", fpm_a, 32'd0);
        cyc();
        rst = 1'b0;

        // single issue
        cdb_grant = 1'b1;
        rs_ready = 4'b0001;
        @(negedge clk);
        check("t1_grant", 32'(rs_grant), 32'h1);
        cyc();
        rs_ready = '0;
        repeat (3) cyc();
        @(negedge clk);
        check("t1_req", 32'(cdb_req), 32'd1);
        check("t1_tag", 32'(cdb_tag), 32'd5);
        check("t1_data", cdb_data, 32'h41900000);
        cyc();
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd0);

        // round-robin fairness
        do_reset();
        cdb_grant = 1'b1;
        rs_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_grant", 32'(rs_grant), 32'(1) << i);
            cyc();
        end
        repeat (4) cyc();
        rs_ready = '0;
        repeat (10) cyc();

        // backpressure
        do_reset();
        cdb_grant = 1'b0;
        rs_ready = 4'hF;
        repeat (10) cyc();
        @(negedge clk);
        check("bp_full_grant", 32'(rs_grant), 32'd0);
        check("bp_full_req", 32'(cdb_req), 32'd1);
        check("bp_head_tag", 32'(cdb_tag), 32'd5);
        cyc();
        cdb_grant = 1'b1;
        @(negedge clk);
        check("bp_pop_grant", 32'(rs_grant), 32'd0);
        cyc();
        cdb_grant = 1'b0;
        @(negedge clk);
        check("bp_regrant", 32'(rs_grant), 32'h1);
        cyc();
        rs_ready = '0;
        cdb_grant = 1'b1;
        repeat (12) cyc();

        // steady traffic with mixed backpressure
        for (int i = 0; i < 24; i++) begin
            rs_ready  = PAT[i % 8];
            cdb_grant = (i % 3) != 2;
            cyc();
        end
        rs_ready = '0;
        cdb_grant = 1'b1;
        repeat (12) cyc();

        // flush mid-flight
        do_reset();
        cdb_grant = 1'b1;
        rs_ready = 4'b0011;
        cyc();
        cyc();
        flush = 1'b1;
        @(negedge clk);
        check("fl_nogrant", 32'(rs_grant), 32'd0);
        cyc();
        flush = 1'b0;
        rs_ready = 4'hF;
        @(negedge clk);
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_req", 32'(cdb_req), 32'd0);
        check("fl_rrptr", 32'(rs_grant), 32'h4);
        cyc();
        rs_ready = '0;
        repeat (8) cyc();

        // reset with a full buffer
        cdb_grant = 1'b0;
        rs_ready = 4'hF;
        repeat (8) cyc();
        rs_ready = 4'b1010;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("mr_req", 32'(cdb_req), 32'd0);
        check("mr_grant", 32'(rs_grant), 32'h2);
        cyc();
        rs_ready = '0;
        cdb_grant = 1'b1;
        repeat (10) cyc();

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
